// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, reset fetch address and the
// {pc, data} record carried through the fetch buffer.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched program bytes. The head is read
// straight from the storage registers, so the output has no path from the write data.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     entry_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] count_q;

  // Flush keeps the stored bytes but empties the queue; they are never shown as valid again.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= entry_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the block ROM address, hides its
// one-cycle read latency and hands PC-tagged bytes to the core.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic [ADDR_W-1:0] byte_pc,
  input  logic              byte_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DepthLimit = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] romAddr_q, romAddr_d;
  logic [ADDR_W-1:0] inflightPc_q, inflightPc_d;
  logic              inflight_q, inflight_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifoCount;
  fetch_entry_t      pushEntry;
  fetch_entry_t      headEntry;

  assign pop       = byte_valid & byte_ready;
  assign push      = inflight_q & ~redirect;
  assign pushEntry = '{pc: inflightPc_q, data: rom_data};

  // The byte in flight already owns a buffer slot, so it counts toward the limit.
  always_comb begin
    occupancy = {1'b0, fifoCount} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    issue     = ~redirect && (occupancy < DepthLimit);
  end

  always_comb begin
    romAddr_d    = romAddr_q;
    inflightPc_d = inflightPc_q;
    inflight_d   = 1'b0;
    if (redirect) begin
      romAddr_d = redirect_pc;
    end else if (issue) begin
      inflight_d   = 1'b1;
      inflightPc_d = romAddr_q;
      romAddr_d    = romAddr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      romAddr_q    <= RESET_PC;
      inflightPc_q <= RESET_PC;
      inflight_q   <= 1'b0;
    end else begin
      romAddr_q    <= romAddr_d;
      inflightPc_q <= inflightPc_d;
      inflight_q   <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .entry_i (pushEntry),
    .head_o  (headEntry),
    .count_o (fifoCount)
  );

  assign rom_address = romAddr_q;
  assign byte_valid  = (fifoCount != '0);
  assign byte_data   = headEntry.data;
  assign byte_pc     = headEntry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table, then
// back-to-back redirects and a randomly stalled stream checked against a PC counter.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] romAddress;
  logic [DATA_W-1:0] romData = '0;
  logic              byteValid;
  logic [DATA_W-1:0] byteData;
  logic [ADDR_W-1:0] bytePc;
  logic              byteReady = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirectPc = '0;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       expValid;
    logic [7:0] expPc;
    logic [7:0] expData;
    logic [7:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .rom_address (romAddress),
    .rom_data    (romData),
    .byte_valid  (byteValid),
    .byte_data   (byteData),
    .byte_pc     (bytePc),
    .byte_ready  (byteReady),
    .redirect    (redirect),
    .redirect_pc (redirectPc)
  );

  always #5 clock = ~clock;

  // Synchronous-read ROM holding M[a] = a ^ A5.
  always @(posedge clock) romData <= romAddress ^ 8'hA5;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic redir,
                              input logic [7:0] rpc, input logic ev,
                              input logic [7:0] ep, input logic [7:0] ed,
                              input logic [7:0] ea);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.expValid = ev; v.expPc = ep; v.expData = ed; v.expAddr = ea;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset      = v.rst;
    byteReady  = v.rdy;
    redirect   = v.redir;
    redirectPc = v.rpc;
  endtask

  task automatic addStartup();
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 8'hA5, 8'h02));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h01, 8'hA4, 8'h03));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h02, 8'hA7, 8'h04));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h03, 8'hA6, 8'h05));
  endtask

  initial begin
    int popped;
    logic [7:0] expPc;
    logic seenValid;

    // Startup latency and streaming
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00));
    addStartup();
    // Backpressure from release, then drain
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h01));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 8'h02));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 8'h02));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 8'h02));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h01, 8'hA4, 8'h03));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h02, 8'hA7, 8'h04));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h03, 8'hA6, 8'h05));
    // Redirect to 40 with a byte buffered and one in flight
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h01));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 8'h02));
    vecs.push_back(mk(0, 0, 1, 8'h40, 0, 8'h00, 8'h00, 8'h40));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h41));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h40, 8'hE5, 8'h42));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h41, 8'hE4, 8'h43));
    // Redirect to FE and wrap through 00
    vecs.push_back(mk(0, 1, 1, 8'hFE, 0, 8'h00, 8'h00, 8'hFE));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'hFE, 8'h5B, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'hFF, 8'h5A, 8'h01));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 8'hA5, 8'h02));
    // Redirect to 10 while popping with a push pending
    vecs.push_back(mk(0, 1, 1, 8'h10, 0, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h11));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h10, 8'hB5, 8'h12));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h11, 8'hB4, 8'h13));
    // Reset with a byte in flight, then startup repeats
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00));
    addStartup();
    // Fill the buffer, reset while full, then startup repeats
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h03, 8'hA6, 8'h05));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h03, 8'hA6, 8'h05));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00));
    addStartup();

    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clock);
      checkOutput($sformatf("row%0d valid", i), 32'(byteValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d rom_address", i), 32'(romAddress), 32'(vecs[i].expAddr));
      if (vecs[i].rst || vecs[i].expValid) begin
        checkOutput($sformatf("row%0d byte_pc", i), 32'(bytePc), 32'(vecs[i].expPc));
        checkOutput($sformatf("row%0d byte_data", i), 32'(byteData), 32'(vecs[i].expData));
      end
    end

    // Back-to-back redirects: only the second target may appear
    byteReady = 1'b1; reset = 1'b0;
    redirect = 1'b1; redirectPc = 8'h80;
    @(negedge clock);
    redirectPc = 8'h90;
    @(negedge clock);
    redirect = 1'b0;
    seenValid = 1'b0;
    for (int c = 0; c < 10 && !seenValid; c++) begin
      @(negedge clock);
      if (byteValid) begin
        seenValid = 1'b1;
        checkOutput("b2b redirect pc", 32'(bytePc), 32'h90);
        checkOutput("b2b redirect data", 32'(byteData), 32'h35);
      end
    end
    checkOutput("b2b redirect seen", 32'(seenValid), 32'h1);

    // Random backpressure: every popped byte must follow the previous one
    reset = 1'b1; byteReady = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    popped = 0;
    expPc = 8'h00;
    for (int c = 0; c < 400 && popped < 40; c++) begin
      byteReady = 1'($urandom_range(0, 1));
      if (byteValid && byteReady) begin
        checkOutput($sformatf("stream pc %0d", popped), 32'(bytePc), 32'(expPc));
        checkOutput($sformatf("stream data %0d", popped), 32'(byteData), 32'(expPc ^ 8'hA5));
        expPc = expPc + 8'h01;
        popped++;
      end
      @(negedge clock);
    end
    checkOutput("stream pops", 32'(popped), 32'd40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
